// File: rtl/multdivid_operand_shifter.sv
// ----------------------------------------------------------------------------
// multdivid_operand_shifter
//
// Operand register for the multiply/divide unit. It holds a WIDTH-bit operand
// that is loaded on WE. On start it shifts left or right by one bit per clock
// for ITER clocks, counted by an internal down-counter. The bit at the leading
// edge of the shift is presented on shift_out. busy and done report progress
// to the MultDivid sequencer.
//
// Optional feature macro: MULTDIVID_SIGNEXT_EN
//   defined     : right shifts are arithmetic (the MSB is replicated).
//   not defined : right shifts take shift_in as the fill bit, so both
//                 directions behave as a logical/serial shift.
//
// Reset is synchronous and active-high on port `reset`.
// ----------------------------------------------------------------------------
module multdivid_operand_shifter #(
    parameter int WIDTH = 34,   // operand width in bits, at least 2
    parameter int ITER  = 32,   // shift clocks per operation, 0 allowed
    parameter int CNT_W = 6     // counter width, 2**CNT_W must exceed ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             WE,
    input  logic             start,
    input  logic             dir,
    input  logic             shift_in,
    output logic [WIDTH-1:0] value_out,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    // Values derived once from the parameters.
    localparam logic [CNT_W-1:0] ITER_CNT  = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               ZERO_ITER = (ITER == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] value_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             dir_reg;
    logic             busy_reg;
    logic             done_reg;

    // Candidate next register contents, one for each shift direction.
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic             fill_bit;

    // This selects the bit that enters at the MSB on a right shift.
`ifdef MULTDIVID_SIGNEXT_EN
    assign fill_bit = value_reg[WIDTH-1];
`else
    assign fill_bit = shift_in;
`endif

    // Each bit takes its neighbour's value. The end bits take the serial input
    // or the fill bit instead.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
            if (gi == 0) begin : g_lsb
                assign shl_next[gi] = shift_in;
            end else begin : g_lsb_n
                assign shl_next[gi] = value_reg[gi-1];
            end

            if (gi == WIDTH - 1) begin : g_msb
                assign shr_next[gi] = fill_bit;
            end else begin : g_msb_n
                assign shr_next[gi] = value_reg[gi+1];
            end
        end
    endgenerate

    // This FSM handles loading, sequencing the shifts, and the registered
    // busy and done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            value_reg <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // A load in the same cycle as start is seen by the first shift.
                    if (WE) begin
                        value_reg <= value;
                    end
                    if (start) begin
                        dir_reg <= dir;
                        cnt_reg <= ITER_CNT;
                        if (ZERO_ITER) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_SHIFT;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end

                ST_SHIFT: begin
                    // WE, start and dir are ignored here. dir_reg holds its value
                    // for the whole operation.
                    value_reg <= dir_reg ? shr_next : shl_next;
                    cnt_reg   <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign value_out = value_reg;
    assign shift_out = dir_reg ? value_reg[0] : value_reg[WIDTH-1];
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_multdivid_operand_shifter.sv
// ----------------------------------------------------------------------------
// tb_multdivid_operand_shifter
//
// Directed bench with three instances: ITER=32, ITER=4 and ITER=0. Expected
// results are pushed to a scoreboard queue when an operation is launched. They
// are popped and compared when that instance raises done. The expected values
// depend on MULTDIVID_SIGNEXT_EN.
// ----------------------------------------------------------------------------
module tb_multdivid_operand_shifter;

    localparam int W = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] value;
    logic         dir;
    logic         shift_in;
    logic         we    [3];
    logic         start [3];
    logic [W-1:0] vo    [3];
    logic         so    [3];
    logic         busy  [3];
    logic         done  [3];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [$];
    string        tag_q [$];

    multdivid_operand_shifter #(.WIDTH(W), .ITER(32), .CNT_W(6)) u_it32 (
        .clk(clk), .reset(reset), .value(value), .WE(we[0]), .start(start[0]),
        .dir(dir), .shift_in(shift_in), .value_out(vo[0]), .shift_out(so[0]),
        .busy(busy[0]), .done(done[0])
    );

    multdivid_operand_shifter #(.WIDTH(W), .ITER(4), .CNT_W(3)) u_it4 (
        .clk(clk), .reset(reset), .value(value), .WE(we[1]), .start(start[1]),
        .dir(dir), .shift_in(shift_in), .value_out(vo[1]), .shift_out(so[1]),
        .busy(busy[1]), .done(done[1])
    );

    multdivid_operand_shifter #(.WIDTH(W), .ITER(0), .CNT_W(2)) u_it0 (
        .clk(clk), .reset(reset), .value(value), .WE(we[2]), .start(start[2]),
        .dir(dir), .shift_in(shift_in), .value_out(vo[2]), .shift_out(so[2]),
        .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic load(input int idx, input logic [W-1:0] v);
        value    = v;
        we[idx]  = 1'b1;
        tick();
        we[idx]  = 1'b0;
    endtask

    // Launch one operation and wait, with a bound, for done. Then check the
    // latency and the flags, and pop the expected result.
    task automatic run_op(input int idx, input logic d, input logic si,
                          input int n_iter, input bit disturb);
        int           edges;
        bit           overlap;
        string        t;
        logic [W-1:0] e;
        t          = tag_q[0];
        overlap    = 1'b0;
        dir        = d;
        shift_in   = si;
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
        edges      = 1;
        check({t, "_busy_after_start"}, 64'(busy[idx]), 64'(n_iter > 0));
        while (!done[idx] && edges < 200) begin
            if (disturb && edges == 2) begin
                we[idx] = 1'b1;
                value   = 34'h0_0000_AAAA;
                dir     = ~d;
            end else begin
                we[idx] = 1'b0;
            end
            tick();
            edges++;
            if (busy[idx] && done[idx]) overlap = 1'b1;
        end
        we[idx] = 1'b0;
        dir     = d;
        check({t, "_done"}, 64'(done[idx]), 64'd1);
        check({t, "_edges"}, 64'(edges), 64'(n_iter + 1));
        check({t, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        check({t, "_busy_at_done"}, 64'(busy[idx]), 64'd0);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_value"}, 64'(vo[idx]), 64'(e));
        $display("op %s: idx=%0d dir=%0b edges=%0d value_out=0x%0h", t, idx, d, edges, vo[idx]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_r32;
        logic [W-1:0] exp_r4;
`ifdef MULTDIVID_SIGNEXT_EN
        exp_r32 = 34'h3_FFFF_FFFE;
        exp_r4  = 34'h0_0000_000F;
`else
        exp_r32 = 34'h0_0000_0002;
        exp_r4  = 34'h3_C000_000F;
`endif
        // Hold reset while WE is asserted. Reset has priority over the load.
        reset    = 1'b1;
        value    = 34'h3_FFFF_FFFF;
        dir      = 1'b0;
        shift_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we[i]    = 1'b1;
            start[i] = 1'b0;
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) we[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_value%0d", i), 64'(vo[i]), 64'd0);
            check($sformatf("reset_busy%0d", i), 64'(busy[i]), 64'd0);
            check($sformatf("reset_done%0d", i), 64'(done[i]), 64'd0);
            check($sformatf("reset_shout%0d", i), 64'(so[i]), 64'd0);
        end
        $display("reset: checked all instances");

        // Single-edge load. shift_out shows the MSB while dir_q is 0.
        load(0, 34'h2_0000_0001);
        check("load_value", 64'(vo[0]), 64'h2_0000_0001);
        check("load_shout", 64'(so[0]), 64'd1);
        check("load_busy", 64'(busy[0]), 64'd0);
        $display("load: value_out=0x%0h", vo[0]);

        // Left shift with ITER=4.
        load(1, 34'h1);
        push("left4", 34'h10);
        run_op(1, 1'b0, 1'b0, 4, 1'b0);

        // WE alone in DONE loads the value and stays in DONE.
        load(1, 34'h7);
        check("done_we_value", 64'(vo[1]), 64'h7);
        check("done_we_done", 64'(done[1]), 64'd1);
        check("done_we_busy", 64'(busy[1]), 64'd0);
        $display("done+we: value_out=0x%0h done=%0b", vo[1], done[1]);

        // A right shift with shift_in=1 started from DONE. The fill bit
        // depends on the build option.
        load(1, 34'h0_0000_00F0);
        push("right4_fill1", exp_r4);
        run_op(1, 1'b1, 1'b1, 4, 1'b0);
        check("right4_shout_lsb", 64'(so[1]), 64'd1);

        // Right shift with ITER=32.
        load(0, 34'h2_0000_0000);
        push("right32", exp_r32);
        run_op(0, 1'b1, 1'b0, 32, 1'b0);

        // The same operation with WE and dir disturbed mid-shift.
        load(0, 34'h2_0000_0000);
        push("right32_disturbed", exp_r32);
        run_op(0, 1'b1, 1'b0, 32, 1'b1);

        // Left shift with ITER=32 and shift_in=1. Only the two low bits of
        // the operand survive, in the top two positions.
        load(0, 34'h1_2345_6789);
        push("left32_fill1", 34'h1_FFFF_FFFF);
        run_op(0, 1'b0, 1'b1, 32, 1'b0);

        // Reset at the third shifting edge aborts the operation.
        load(0, 34'h3_0000_0001);
        dir      = 1'b0;
        shift_in = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        check("midreset_busy_before", 64'(busy[0]), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_value", 64'(vo[0]), 64'd0);
        check("midreset_busy", 64'(busy[0]), 64'd0);
        check("midreset_done", 64'(done[0]), 64'd0);
        check("midreset_it4_done", 64'(done[1]), 64'd0);
        $display("mid-shift reset: value_out=0x%0h busy=%0b done=%0b", vo[0], busy[0], done[0]);

        // ITER=0 with WE and start in the same cycle.
        push("iter0_we_start", 34'h5);
        value    = 34'h5;
        we[2]    = 1'b1;
        start[2] = 1'b1;
        tick();
        we[2]    = 1'b0;
        start[2] = 1'b0;
        check("iter0_done", 64'(done[2]), 64'd1);
        check("iter0_busy", 64'(busy[2]), 64'd0);
        begin
            logic [W-1:0] e;
            string        t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_value"}, 64'(vo[2]), 64'(e));
            $display("op %s: value_out=0x%0h done=%0b", t, vo[2], done[2]);
        end

        // Restarting from DONE with ITER=0 leaves the value unchanged.
        push("iter0_restart", 34'h5);
        run_op(2, 1'b1, 1'b1, 0, 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
